pll_lock_supervisor: RTL
========================

// Module: pll_lock_supervisor
// PURPOSE
//  Counterpart of the PLL reset/locked handshake: drives the PLL's rst input and consumes its async locked output.
//  Issues a timed PLL reset and waits for lock, retrying on timeout.
//  Releases sys_rst_n only after lock has been continuously stable; re-sequences on loss of lock.
//  Runs on refclk (50 MHz board clock). Downstream logic resynchronises sys_rst_n into outclk_0.
// PARAMETERS
//  SYNC_STAGES       2      flops in the pll_locked synchroniser (>=2)
//  RST_PULSE_CYC     16     refclk cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT_CYC  50000  cycles to wait for locked after pll_rst release (1 ms)
//  LOCK_STABLE_CYC   1000   consecutive synchronised-locked cycles before release (20 us)
//  MAX_RETRIES       3      failed attempts before entering FAIL (1..7)
// PORTS
//  refclk      in   1  clock; all logic is on its rising edge
//  rst_n       in   1  synchronous active-low reset
//  pll_locked  in   1  PLL locked flag; asynchronous to refclk
//  pll_rst     out  1  active-high reset to the PLL
//  sys_rst_n   out  1  active-low system reset; 1 only in RUN
//  lock_lost   out  1  one-cycle pulse when lock drops in RUN
//  lock_fail   out  1  sticky; MAX_RETRIES timeouts occurred
//  retry_cnt   out  3  timeouts in the current sequence
//  state_o     out  3  current FSM state encoding (debug)
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=PULSE, counters=0, sync flops=0, pll_rst=1, sys_rst_n=0, lock_fail=0, lock_lost=0, retry_cnt=0.
//  lk = last synchroniser stage. All outputs are registered.
//  PULSE: pll_rst=1 for exactly RST_PULSE_CYC cycles, then WAIT; timer cleared.
//  WAIT:  pll_rst=0; timer counts.
//   - lk=1 -> STABLE, stable counter=0.
//   - Timer reaches LOCK_TIMEOUT_CYC-1 with lk=0 -> retry_cnt+1.
//   - If new retry_cnt==MAX_RETRIES -> FAIL; else -> PULSE.
//   - lk=1 and timeout in the same cycle: lock wins (-> STABLE).
//  STABLE: counts consecutive lk=1.
//   - Any lk=0 -> back to WAIT with timer restarted; retry_cnt unchanged.
//   - Count reaches LOCK_STABLE_CYC -> RUN; retry_cnt cleared.
//  RUN: sys_rst_n=1.
//   - lk=0 -> lock_lost=1 for one cycle, sys_rst_n=0 on the same edge, -> PULSE.
//  FAIL: pll_rst=0, sys_rst_n=0, lock_fail=1. Held until rst_n; pll_locked is ignored.
//  Latency: pll_locked rise to sys_rst_n=1 is SYNC_STAGES+LOCK_STABLE_CYC+1 edges.
//   pll_locked fall in RUN to sys_rst_n=0 is SYNC_STAGES+1 edges.
//  Counters saturate and never wrap. Widths are $clog2(param+1).
//  A lock glitch shorter than one refclk period may be missed; this is acceptable.
//  rst_n asserted mid-sequence restarts at PULSE from any state, including FAIL.
// STRUCTURE
//  pll_sup_pkg: state enum (PULSE, WAIT, STABLE, RUN, FAIL) and counter-width localparam functions.
//  Sub-module sync_bit #(STAGES): reset-to-0 multi-flop synchroniser for pll_locked.
//  Top level: one shared down/up timer reused across PULSE, WAIT and STABLE; retry counter; FSM.
// TESTING (bench params: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=32, LOCK_STABLE_CYC=8, MAX_RETRIES=2, SYNC_STAGES=2)
//  1. Release rst_n; model PLL asserts locked 10 cycles after pll_rst falls.
//     Expect pll_rst high exactly 4 cycles, then sys_rst_n rises 11 cycles after locked.
//  2. Locked held low.
//     Expect two 4-cycle pll_rst pulses 32 cycles apart, retry_cnt 1 then 2, then lock_fail=1.
//     pll_rst stays 0 and later locked=1 is ignored.
//  3. In STABLE, drop locked for 1 cycle at stable count 5.
//     Expect return to WAIT and full 8-cycle recount; sys_rst_n not released early.
//  4. In RUN, drop locked.
//     Expect lock_lost single pulse and sys_rst_n=0 3 edges after the fall, then a new 4-cycle pll_rst pulse.
//  5. Locked rises on the exact timeout cycle.
//     Expect STABLE entered and retry_cnt not incremented.
//  6. Assert rst_n for 1 cycle while in FAIL and while in RUN.
//     Expect all outputs at reset values next edge and sequence restarts at PULSE.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and width helpers for the PLL lock supervisor.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      ST_PULSE  = 3'd0,
      ST_WAIT   = 3'd1,
      ST_STABLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_FAIL   = 3'd4
   } pll_state_e;

   function automatic int cnt_width(input int val);
      return (val < 1) ? 1 : $clog2(val + 1);
   endfunction

   // The shared timer must hold the largest of the three phase lengths.
   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return cnt_width(m);
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic refclk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge refclk) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock, then releases the system reset.
//
// state  | meaning
// PULSE  | pll_rst held high for RST_PULSE_CYC cycles
// WAIT   | pll_rst released, waiting for lock until timeout
// STABLE | lock seen, counting consecutive locked cycles
// RUN    | lock stable, sys_rst_n released
// FAIL   | MAX_RETRIES timeouts; parked until rst_n
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int SYNC_STAGES      = 2,
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_TIMEOUT_CYC = 50000,
   parameter int LOCK_STABLE_CYC  = 1000,
   parameter int MAX_RETRIES      = 3
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       lock_lost,
   output logic       lock_fail,
   output logic [2:0] retry_cnt,
   output logic [2:0] state_o
);

   localparam int TW = timer_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
   localparam logic [TW-1:0] PULSE_LOAD   = TW'(RST_PULSE_CYC - 1);
   localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] STABLE_LOAD  = TW'(LOCK_STABLE_CYC - 1);
   localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
   localparam logic [2:0]    RETRY_MAX    = 3'(MAX_RETRIES);

   pll_state_e    state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [2:0]    retry_nxt;
   logic          lock_lost_nxt;
   logic          lk;

   sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .refclk (refclk),
      .rst_n  (rst_n),
      .d      (pll_locked),
      .q      (lk)
   );

   // Single down-counter reloaded on every state entry; terminal count is 0.
   always_comb begin
      state_nxt     = state;
      timer_nxt     = timer;
      retry_nxt     = retry_cnt;
      lock_lost_nxt = 1'b0;
      case (state)
         ST_PULSE: begin
            if (timer == '0) begin
               state_nxt = ST_WAIT;
               timer_nxt = TIMEOUT_LOAD;
            end else begin
               timer_nxt = timer - TIMER_ONE;
            end
         end
         ST_WAIT: begin
            if (lk) begin
               state_nxt = ST_STABLE;
               timer_nxt = STABLE_LOAD;
            end else if (timer == '0) begin
               if (retry_cnt != RETRY_MAX) retry_nxt = retry_cnt + 3'd1;
               if (retry_nxt == RETRY_MAX) begin
                  state_nxt = ST_FAIL;
               end else begin
                  state_nxt = ST_PULSE;
                  timer_nxt = PULSE_LOAD;
               end
            end else begin
               timer_nxt = timer - TIMER_ONE;
            end
         end
         ST_STABLE: begin
            if (!lk) begin
               state_nxt = ST_WAIT;
               timer_nxt = TIMEOUT_LOAD;
            end else if (timer == '0) begin
               state_nxt = ST_RUN;
               retry_nxt = '0;
            end else begin
               timer_nxt = timer - TIMER_ONE;
            end
         end
         ST_RUN: begin
            if (!lk) begin
               lock_lost_nxt = 1'b1;
               state_nxt     = ST_PULSE;
               timer_nxt     = PULSE_LOAD;
            end
         end
         ST_FAIL: begin
            state_nxt = ST_FAIL;
         end
         default: begin
            state_nxt = ST_PULSE;
            timer_nxt = PULSE_LOAD;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as state.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state     <= ST_PULSE;
         timer     <= PULSE_LOAD;
         retry_cnt <= '0;
         pll_rst   <= 1'b1;
         sys_rst_n <= 1'b0;
         lock_lost <= 1'b0;
         lock_fail <= 1'b0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         retry_cnt <= retry_nxt;
         pll_rst   <= (state_nxt == ST_PULSE);
         sys_rst_n <= (state_nxt == ST_RUN);
         lock_lost <= lock_lost_nxt;
         lock_fail <= (state_nxt == ST_FAIL);
      end
   end

   assign state_o = state;

endmodule
